// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter: a winner is latched one edge after its request is
// sampled and granted on the following edge, with the grant held up to MAX_HOLD cycles.
module req_grant_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           busy,
    output logic           hold_timeout
);

    typedef enum logic [1:0] {StIdle, StPend, StGrant} state_e;

    state_e         r_state, w_state_d;
    logic [N-1:0]   r_gnt, w_gnt_d;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_d;
    logic [IDW-1:0] r_ptr, w_ptr_d;
    logic           r_vld, w_vld_d;
    logic           r_to, w_to_d;
    logic [7:0]     r_hold, w_hold_d;
    logic [IDW-1:0] w_win;
    logic           w_found;
    logic [IDW-1:0] w_next_ptr;
    logic [N-1:0]   w_onehot;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int unsigned b);
        int unsigned s;
        s = (32'(a) + b) % N;
        return IDW'(s);
    endfunction

    // First requester at or above the priority pointer, wrapping N-1 -> 0.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && req[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_ptr, i);
            end
        end
    end

    assign w_next_ptr = wrap_add(r_gnt_id, 1);
    assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << r_gnt_id;

    always_comb begin
        w_state_d  = r_state;
        w_gnt_d    = r_gnt;
        w_gnt_id_d = r_gnt_id;
        w_ptr_d    = r_ptr;
        w_vld_d    = r_vld;
        w_to_d     = 1'b0;
        w_hold_d   = r_hold;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_gnt_id_d = w_win;
                    w_state_d  = StPend;
                end
            end
            StPend: begin
                if (req[r_gnt_id]) begin
                    w_gnt_d   = w_onehot;
                    w_vld_d   = 1'b1;
                    w_hold_d  = 8'd1;
                    w_state_d = StGrant;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StGrant: begin
                // Release and timeout both rotate priority past the current winner.
                if (!req[r_gnt_id] || r_hold == 8'(MAX_HOLD)) begin
                    w_gnt_d   = '0;
                    w_vld_d   = 1'b0;
                    w_ptr_d   = w_next_ptr;
                    w_to_d    = req[r_gnt_id];
                    w_state_d = StIdle;
                end else if (r_hold != 8'hff) begin
                    w_hold_d = r_hold + 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_vld    <= 1'b0;
            r_to     <= 1'b0;
            r_hold   <= 8'd0;
        end else begin
            r_state  <= w_state_d;
            r_gnt    <= w_gnt_d;
            r_gnt_id <= w_gnt_id_d;
            r_ptr    <= w_ptr_d;
            r_vld    <= w_vld_d;
            r_to     <= w_to_d;
            r_hold   <= w_hold_d;
        end
    end

    assign gnt          = r_gnt;
    assign gnt_id       = r_gnt_id;
    assign gnt_vld      = r_vld;
    assign busy         = (r_state != StIdle);
    assign hold_timeout = r_to;

endmodule
